// File: rtl/compositor_pkg.sv
// Shared types and helpers for the layer compositor: pixel struct, default colour key,
// and the strict-priority winner picker (lowest set index wins).
package compositor_pkg;

  localparam int RGB_CH_W   = 4;
  localparam int MAX_LAYERS = 32;
  localparam int IDX_W      = 5;

  typedef struct packed {
    logic [RGB_CH_W-1:0] r;
    logic [RGB_CH_W-1:0] g;
    logic [RGB_CH_W-1:0] b;
  } rgb_t;

  localparam rgb_t KEY_RGB_DEFAULT = '{r: 4'hF, g: 4'h0, b: 4'hF};

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] index;
  } winner_t;

  // Scanning from the top down lets the lowest set index overwrite all others.
  function automatic winner_t pick_winner(input logic [MAX_LAYERS-1:0] layer_on);
    winner_t w;
    w = '0;
    for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
      if (layer_on[i]) begin
        w.valid = 1'b1;
        w.index = IDX_W'(i);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/flash_counter.sv
// Per-layer hit-flash counter: loads FLASH_FRAMES on a hit and counts frames down to zero;
// odd nonzero counts mark the layer as flash-white.
module flash_counter #(
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_W      = 8
) (
  input  logic vga_clk,
  input  logic Reset,
  input  logic frame_start,
  input  logic hit,
  output logic flashing,
  output logic white
);

  logic [FLASH_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (hit) begin
      cnt <= FLASH_W'(FLASH_FRAMES);
    end else if (frame_start && (cnt != '0)) begin
      cnt <= cnt - FLASH_W'(1);
    end
  end

  assign flashing = (cnt != '0);
  assign white    = flashing & cnt[0];

endmodule

// File: rtl/layer_compositor.sv
// Two-stage strict-priority layer compositor with per-layer hit flash and blank forcing.
// Define TRANSPARENT_KEY_EN to make KEY_RGB-coloured layer pixels transparent.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS   = 4,
  parameter int COLOR_W      = 4,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_W      = 8
`ifdef TRANSPARENT_KEY_EN
  ,
  parameter logic [3*COLOR_W-1:0] KEY_RGB = (3*COLOR_W)'(KEY_RGB_DEFAULT)
`endif
) (
  input  logic                             vga_clk,
  input  logic                             Reset,
  input  logic                             frame_start,
  input  logic                             blank,
  input  logic [3*COLOR_W-1:0]             bg_rgb,
  input  logic [NUM_LAYERS-1:0]            layer_on,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]  layer_rgb,
  input  logic [NUM_LAYERS-1:0]            hit,
  output logic [NUM_LAYERS-1:0]            flashing,
  output logic [COLOR_W-1:0]               Red,
  output logic [COLOR_W-1:0]               Green,
  output logic [COLOR_W-1:0]               Blue
);

  localparam int PIX_W = 3 * COLOR_W;

  logic [NUM_LAYERS-1:0] white;
  logic [NUM_LAYERS-1:0] visible;
  logic [MAX_LAYERS-1:0] white_ext;
  winner_t               win;
  logic [PIX_W-1:0]      win_rgb;

  logic                  s1_blank;
  logic [PIX_W-1:0]      s1_bg;
  logic                  s1_valid;
  logic [IDX_W-1:0]      s1_idx;
  logic [PIX_W-1:0]      s1_rgb;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_flash
    flash_counter #(
      .FLASH_FRAMES (FLASH_FRAMES),
      .FLASH_W      (FLASH_W)
    ) u_flash (
      .vga_clk     (vga_clk),
      .Reset       (Reset),
      .frame_start (frame_start),
      .hit         (hit[i]),
      .flashing    (flashing[i]),
      .white       (white[i])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    visible = layer_on;
`ifdef TRANSPARENT_KEY_EN
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (layer_rgb[i*PIX_W +: PIX_W] == KEY_RGB) visible[i] = 1'b0;
    end
`endif
  end

  always_comb begin
    win     = pick_winner(MAX_LAYERS'(visible));
    win_rgb = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (win.valid && (win.index == IDX_W'(i))) win_rgb = layer_rgb[i*PIX_W +: PIX_W];
    end
  end

  // NOTE: reset is synchronous and clears every pipeline flop, so a mid-frame reset never leaks stale pixels.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      s1_blank <= 1'b0;
      s1_bg    <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_rgb   <= '0;
    end else begin
      s1_blank <= blank;
      s1_bg    <= bg_rgb;
      s1_valid <= win.valid;
      s1_idx   <= win.index;
      s1_rgb   <= win_rgb;
    end
  end

  // Flash state is read live in stage 2, so a hit lands one cycle before its pixel exits.
  assign white_ext = MAX_LAYERS'(white);

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      {Red, Green, Blue} <= '0;
    end else if (!s1_blank) begin
      {Red, Green, Blue} <= '0;
    end else if (!s1_valid) begin
      {Red, Green, Blue} <= s1_bg;
    end else if (white_ext[s1_idx]) begin
      {Red, Green, Blue} <= '1;
    end else begin
      {Red, Green, Blue} <= s1_rgb;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: frame-level reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_layer_compositor;

  localparam int NL = 4;
  localparam int CW = 4;
  localparam int PW = 3 * CW;

  logic            vga_clk = 1'b0;
  logic            Reset = 1'b1;
  logic            frame_start = 1'b0;
  logic            blank = 1'b1;
  logic [PW-1:0]   bg_rgb = '0;
  logic [NL-1:0]   layer_on = '0;
  logic [NL*PW-1:0] layer_rgb = '0;
  logic [NL-1:0]   hit = '0;
  logic [NL-1:0]   flashing;
  logic [CW-1:0]   Red, Green, Blue;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  always #5 vga_clk = ~vga_clk;

  layer_compositor #(
    .NUM_LAYERS   (NL),
    .COLOR_W      (CW),
    .FLASH_FRAMES (8),
    .FLASH_W      (8)
  ) dut (
    .vga_clk     (vga_clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .blank       (blank),
    .bg_rgb      (bg_rgb),
    .layer_on    (layer_on),
    .layer_rgb   (layer_rgb),
    .hit         (hit),
    .flashing    (flashing),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit              blank;
    logic [PW-1:0]   bg;
    logic [NL-1:0]   on;
    logic [NL*PW-1:0] rgb;
  } snap_t;

  snap_t         m_snap;
  int            m_cnt[NL];
  logic [PW-1:0] m_out;

  function automatic bit keyed(input logic [PW-1:0] px);
`ifdef TRANSPARENT_KEY_EN
    return px == 12'hF0F;
`else
    return (px != px);
`endif
  endfunction

  // The pixel a frame-level viewer expects for a captured input set and given flash counts.
  function automatic logic [PW-1:0] compose(input snap_t s, input int c[NL]);
    logic [PW-1:0] px;
    if (!s.blank) return '0;
    for (int i = 0; i < NL; i++) begin
      px = s.rgb[i*PW +: PW];
      if (s.on[i] && !keyed(px)) return (c[i] % 2 == 1) ? '1 : px;
    end
    return s.bg;
  endfunction

  function automatic logic [NL-1:0] model_flashing();
    logic [NL-1:0] f;
    for (int i = 0; i < NL; i++) f[i] = (m_cnt[i] != 0);
    return f;
  endfunction

  always @(posedge vga_clk) begin
    if (Reset) begin
      m_out  <= '0;
      m_snap <= '{blank: 1'b0, bg: '0, on: '0, rgb: '0};
      for (int i = 0; i < NL; i++) m_cnt[i] <= 0;
    end else begin
      m_out  <= compose(m_snap, m_cnt);
      m_snap <= '{blank: blank, bg: bg_rgb, on: layer_on, rgb: layer_rgb};
      for (int i = 0; i < NL; i++) begin
        if (hit[i]) m_cnt[i] <= 8;
        else if (frame_start && m_cnt[i] > 0) m_cnt[i] <= m_cnt[i] - 1;
      end
    end
  end

  always @(negedge vga_clk) begin
    if (check_en) begin
      check("model_rgb", {20'd0, Red, Green, Blue}, {20'd0, m_out});
      check("model_flashing", {28'd0, flashing}, {28'd0, model_flashing()});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
      step(1);
    end
  endtask

  function automatic logic [31:0] pix();
    return {20'd0, Red, Green, Blue};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_cnt;
    // Reset held three edges with every layer on.
    Reset = 1'b1;
    blank = 1'b1;
    layer_on = 4'b1111;
    bg_rgb = 12'h789;
    layer_rgb = {12'h555, 12'h456, 12'h123, 12'hABC};
    step(1);
    check_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("reset_rgb", pix(), 32'h0);
      check("reset_flashing", {28'd0, flashing}, 32'h0);
      if (i < 2) step(1);
    end
    Reset = 1'b0;
    step(1);
    check("release_rgb", pix(), 32'h0);
    check("release_flashing", {28'd0, flashing}, 32'h0);
    step(1);
    check("release_pixel", pix(), 32'hABC);
    check("release_flashing2", {28'd0, flashing}, 32'h0);

    // Priority, background and blank latency.
    layer_on = 4'b0110;
    step(2);
    check("prio_layer1", pix(), 32'h123);
    layer_on = 4'b0000;
    step(2);
    check("background", pix(), 32'h789);
    blank = 1'b0;
    step(1);
    check("blank_latency1", pix(), 32'h789);
    step(1);
    check("blank_black", pix(), 32'h0);
    blank = 1'b1;

    // Full flash sequence on layer 0, plus one extra frame at zero.
    layer_on = 4'b0001;
    layer_rgb = {12'h555, 12'h456, 12'h123, 12'h300};
    hit = 4'b0001;
    step(1);
    hit = 4'b0000;
    check("hit0_flashing", {28'd0, flashing}, 32'h1);
    step(2);
    check("flash0_cnt8", pix(), 32'h300);
    for (int k = 1; k <= 9; k++) begin
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
      step(2);
      exp_cnt = (8 - k > 0) ? 8 - k : 0;
      check("flash0_flashing", {31'd0, flashing[0]}, {31'd0, exp_cnt != 0});
      check("flash0_pixel", pix(), (exp_cnt % 2 == 1) ? 32'hFFF : 32'h300);
    end

    // Hit beats a same-cycle decrement, and a retrigger reloads.
    layer_on = 4'b0100;
    hit = 4'b0100;
    step(1);
    hit = 4'b0000;
    frames(5);
    step(1);
    check("l2_cnt3_white", pix(), 32'hFFF);
    hit = 4'b0100;
    frame_start = 1'b1;
    step(1);
    hit = 4'b0000;
    frame_start = 1'b0;
    step(2);
    check("l2_reload_pixel", pix(), 32'h456);
    frames(7);
    step(1);
    check("l2_cnt1_flashing", {31'd0, flashing[2]}, 32'h1);
    check("l2_cnt1_white", pix(), 32'hFFF);
    frames(1);
    step(1);
    check("l2_cnt0_flashing", {31'd0, flashing[2]}, 32'h0);
    check("l2_cnt0_pixel", pix(), 32'h456);
    hit = 4'b0100;
    step(1);
    hit = 4'b0000;
    frames(6);
    step(1);
    check("l2_cnt2_pixel", pix(), 32'h456);
    hit = 4'b0100;
    step(1);
    hit = 4'b0000;
    frames(7);
    step(1);
    check("l2_retrig_flashing", {31'd0, flashing[2]}, 32'h1);
    frames(1);
    step(1);
    check("l2_retrig_done", {31'd0, flashing[2]}, 32'h0);

    // Reset in the middle of a flash on layer 1.
    layer_on = 4'b0010;
    layer_rgb = {12'h555, 12'h456, 12'h0A0, 12'h300};
    hit = 4'b0010;
    step(1);
    hit = 4'b0000;
    frames(3);
    step(1);
    check("l1_cnt5_white", pix(), 32'hFFF);
    check("l1_cnt5_flashing", {31'd0, flashing[1]}, 32'h1);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    check("midflash_reset_flashing", {28'd0, flashing}, 32'h0);
    check("midflash_reset_rgb", pix(), 32'h0);
    step(2);
    check("midflash_recover_pixel", pix(), 32'h0A0);

    // Colour-key pixel on the top layer.
    layer_on = 4'b0011;
    layer_rgb = {12'h555, 12'h456, 12'h0A0, 12'hF0F};
    step(2);
`ifdef TRANSPARENT_KEY_EN
    check("key_pixel", pix(), 32'h0A0);
`else
    check("key_pixel", pix(), 32'hF0F);
`endif

    step(2);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
